// File: rtl/swipt_rx_decoder.sv
// swipt_rx_decoder
// Receiver-side SWIPT pulse-length decoder. The comparator output is synchronised
// and deglitched. The decoder then measures the period and the high time between
// filtered rising edges, turns the duty into a data bit, and tracks carrier lock.
// Optional feature macro: SWIPT_RX_HYST_EN selects two-threshold (hysteresis)
// decoding. When it is undefined, a single threshold is used.
module swipt_rx_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int DEGLITCH      = 3,
    parameter int CNT_W         = 13,
    parameter int MIN_PERIOD    = 20,
    parameter int MAX_PERIOD    = 4000,
    parameter int THRESH_PERMIL = 350,
    parameter int THRESH_LO     = 300,
    parameter int THRESH_HI     = 400,
    parameter int LOCK_CNT      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             swipt_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] pulse_len,
    output logic             meas_valid,
    output logic             bit_out,
    output logic             lock,
    output logic             err
);

    // State table
    //  S_IDLE | no carrier seen yet, counters cleared, waiting for a rising edge
    //  S_HIGH | inside the high phase of a period, counting high time and period
    //  S_LOW  | inside the low phase, the next rising edge closes the period

    localparam int PW   = CNT_W + 10;
    localparam int DG_W = $clog2(DEGLITCH + 1);
    localparam int LC_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PERIOD);
    localparam logic [PW-1:0]    K_1000  = PW'(1000);

    // Counters saturate at MAX_PERIOD rather than wrap, so that value must fit in CNT_W.
    if ((SYNC_STAGES < 2) || (DEGLITCH < 1) || (LOCK_CNT < 1) ||
        (MIN_PERIOD < 1) || (MAX_PERIOD <= MIN_PERIOD) || (MAX_PERIOD >= (1 << CNT_W)) ||
        (THRESH_PERMIL > 1000) || (THRESH_HI > 1000) || (THRESH_LO > THRESH_HI)) begin : g_cfg_check
        $error("swipt_rx_decoder: illegal parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt;
    logic                   filt_d;
    logic [DG_W-1:0]        dg_cnt;
    logic                   sync_s;
    logic                   rise;
    logic                   fall;

    state_t                 state;
    logic [CNT_W-1:0]       hi_cnt;
    logic [CNT_W-1:0]       per_cnt;
    logic                   v1;
    logic [CNT_W-1:0]       hi_l;
    logic [CNT_W-1:0]       per_l;
    logic [LC_W-1:0]        lock_cnt;
    logic                   bit_next;
    logic [PW-1:0]          prod_hi;
`ifdef SWIPT_RX_HYST_EN
    logic [PW-1:0]          prod_th_hi;
    logic [PW-1:0]          prod_th_lo;
`else
    logic [PW-1:0]          prod_th;
`endif

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = filt & ~filt_d;
    assign fall   = ~filt & filt_d;

    // Synchroniser chain and deglitch filter: filt follows sync_s only after DEGLITCH differing cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            filt   <= 1'b0;
            filt_d <= 1'b0;
            dg_cnt <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], swipt_in};
            filt_d <= filt;
            if (sync_s != filt) begin
                if (dg_cnt == DG_W'(DEGLITCH - 1)) begin
                    filt   <= sync_s;
                    dg_cnt <= '0;
                end else begin
                    dg_cnt <= dg_cnt + DG_W'(1);
                end
            end else begin
                dg_cnt <= '0;
            end
        end
    end

    // Duty decision on the latched period. Full-width products mean the comparison never truncates.
    always_comb begin
        bit_next = 1'b0;
        prod_hi  = PW'(hi_l) * K_1000;
`ifdef SWIPT_RX_HYST_EN
        prod_th_hi = PW'(per_l) * PW'(THRESH_HI);
        prod_th_lo = PW'(per_l) * PW'(THRESH_LO);
        if (prod_hi >= prod_th_hi) begin
            bit_next = 1'b1;
        end else if (prod_hi < prod_th_lo) begin
            bit_next = 1'b0;
        end else begin
            bit_next = bit_out;
        end
`else
        prod_th  = PW'(per_l) * PW'(THRESH_PERMIL);
        bit_next = (prod_hi >= prod_th);
`endif
    end

    // Measurement FSM, result stage and lock tracking; error clears are written last so they win
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            hi_cnt     <= '0;
            per_cnt    <= '0;
            v1         <= 1'b0;
            hi_l       <= '0;
            per_l      <= '0;
            lock_cnt   <= '0;
            period     <= '0;
            pulse_len  <= '0;
            meas_valid <= 1'b0;
            bit_out    <= 1'b0;
            lock       <= 1'b0;
            err        <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            err        <= 1'b0;
            v1         <= 1'b0;
            if (!enable) begin
                state    <= S_IDLE;
                hi_cnt   <= '0;
                per_cnt  <= '0;
                lock     <= 1'b0;
                lock_cnt <= '0;
            end else begin
                if (v1) begin
                    period     <= per_l;
                    pulse_len  <= hi_l;
                    bit_out    <= bit_next;
                    meas_valid <= 1'b1;
                    if (lock_cnt != LC_W'(LOCK_CNT)) begin
                        lock_cnt <= lock_cnt + LC_W'(1);
                    end
                    lock <= (lock_cnt >= LC_W'(LOCK_CNT - 1));
                end
                case (state)
                    S_IDLE: begin
                        hi_cnt  <= '0;
                        per_cnt <= '0;
                        if (rise) begin
                            state   <= S_HIGH;
                            hi_cnt  <= CNT_ONE;
                            per_cnt <= CNT_ONE;
                        end
                    end
                    S_HIGH, S_LOW: begin
                        if (per_cnt == CNT_MAX) begin
                            err      <= 1'b1;
                            lock     <= 1'b0;
                            lock_cnt <= '0;
                            state    <= S_IDLE;
                            hi_cnt   <= '0;
                            per_cnt  <= '0;
                        end else if (state == S_LOW && rise) begin
                            if (per_cnt < CNT_MIN) begin
                                err      <= 1'b1;
                                lock     <= 1'b0;
                                lock_cnt <= '0;
                            end else begin
                                v1    <= 1'b1;
                                hi_l  <= hi_cnt;
                                per_l <= per_cnt;
                            end
                            state   <= S_HIGH;
                            hi_cnt  <= CNT_ONE;
                            per_cnt <= CNT_ONE;
                        end else if (state == S_HIGH) begin
                            per_cnt <= per_cnt + CNT_ONE;
                            if (fall) begin
                                state <= S_LOW;
                            end else begin
                                hi_cnt <= hi_cnt + CNT_ONE;
                            end
                        end else begin
                            per_cnt <= per_cnt + CNT_ONE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_swipt_rx_decoder.sv
// Bench for swipt_rx_decoder: a directed sequence plus random periods. Each
// expected strobe comes from a period-level model built from the raw waveform
// that the bench drives.
module tb_swipt_rx_decoder;

    localparam int CNT_W      = 13;
    localparam int MIN_PERIOD = 20;
    localparam int LOCK_CNT   = 4;
    localparam int LAT        = 2 + 3 + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             swipt_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] pulse_len;
    logic             meas_valid;
    logic             bit_out;
    logic             lock;
    logic             err;

    swipt_rx_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .swipt_in   (swipt_in),
        .period     (period),
        .pulse_len  (pulse_len),
        .meas_valid (meas_valid),
        .bit_out    (bit_out),
        .lock       (lock),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int p;
        int h;
        int b;
        int l;
        int c;
    } rec_t;

    rec_t got_q[$];
    rec_t exp_q[$];
    int   err_seen = 0;

    always @(negedge clk) begin : mon
        rec_t r;
        if (!rst) begin
            if (meas_valid) begin
                r.p = int'(period);
                r.h = int'(pulse_len);
                r.b = int'(bit_out);
                r.l = int'(lock);
                r.c = cyc;
                got_q.push_back(r);
            end
            if (err) err_seen++;
        end
    end

    int total = 0;
    int bad   = 0;

    // model state
    int exp_err    = 0;
    bit pend_valid = 1'b0;
    int pend_p     = 0;
    int pend_h     = 0;
    int run_cnt    = 0;
    int last_bit   = 0;
    int last_p     = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int model_bit(int p, int h);
        int duty_x1000 = h * 1000;
`ifdef SWIPT_RX_HYST_EN
        if (duty_x1000 >= 400 * p) return 1;
        if (duty_x1000 < 300 * p) return 0;
        return last_bit;
`else
        return (duty_x1000 >= 350 * p) ? 1 : 0;
`endif
    endfunction

    // A raw rising edge closes the previously open period, if there is one.
    task automatic model_rise();
        rec_t e;
        if (pend_valid) begin
            if (pend_p < MIN_PERIOD) begin
                exp_err++;
                run_cnt = 0;
            end else begin
                last_bit = model_bit(pend_p, pend_h);
                last_p   = pend_p;
                if (run_cnt < LOCK_CNT) run_cnt++;
                e.p = pend_p;
                e.h = pend_h;
                e.b = last_bit;
                e.l = (run_cnt >= LOCK_CNT) ? 1 : 0;
                e.c = cyc + LAT;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive_period(int p, int h, bit glitch = 1'b0);
        @(negedge clk);
        swipt_in = 1'b1;
        model_rise();
        pend_valid = 1'b1;
        pend_p     = p;
        pend_h     = h;
        repeat (h) @(negedge clk);
        swipt_in = 1'b0;
        if (glitch) begin
            repeat (10) @(negedge clk);
            swipt_in = 1'b1;
            repeat (2) @(negedge clk);
            swipt_in = 1'b0;
            repeat (p - h - 13) @(negedge clk);
        end else begin
            repeat (p - h - 1) @(negedge clk);
        end
    endtask

    task automatic check_all(string tag);
        rec_t e;
        rec_t g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_present"}, 32'(got_q.size() > 0), 32'd1);
            if (got_q.size() > 0) begin
                g = got_q.pop_front();
                chk({tag, "_period"}, g.p, e.p);
                chk({tag, "_pulse_len"}, g.h, e.h);
                chk({tag, "_bit_out"}, g.b, e.b);
                chk({tag, "_lock"}, g.l, e.l);
                chk({tag, "_latency"}, g.c, e.c);
            end
        end
        chk({tag, "_extra_strobes"}, got_q.size(), 0);
        chk({tag, "_err_count"}, err_seen, exp_err);
    endtask

    initial begin
        int p;
        int h;
        rst      = 1'b1;
        enable   = 1'b1;
        swipt_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_period", 32'(period), 0);
        chk("rst_pulse_len", 32'(pulse_len), 0);
        chk("rst_meas_valid", 32'(meas_valid), 0);
        chk("rst_bit_out", 32'(bit_out), 0);
        chk("rst_lock", 32'(lock), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // steady 48% carrier, lock on 4th strobe
        repeat (7) drive_period(100, 48);
        check_all("t1");
        chk("t1_lock_now", 32'(lock), 1);

        // 20% duty while locked
        repeat (3) drive_period(100, 20);
        check_all("t2");
        chk("t2_lock_now", 32'(lock), 1);

        // short glitch in low phase is filtered
        repeat (2) drive_period(100, 48, 1'b1);
        check_all("t3");

        // shortest and longest legal periods
        drive_period(20, 8);
        drive_period(3999, 2000);
        drive_period(100, 48);
        check_all("bound");

        // stuck-high timeout, then relock
        @(negedge clk);
        swipt_in = 1'b1;
        model_rise();
        pend_valid = 1'b0;
        exp_err++;
        run_cnt = 0;
        repeat (4100) @(negedge clk);
        swipt_in = 1'b0;
        chk("t4_lock_after_timeout", 32'(lock), 0);
        chk("t4_err_after_timeout", err_seen, exp_err);
        repeat (50) @(negedge clk);
        repeat (6) drive_period(100, 48);
        check_all("t4");
        chk("t4_relock", 32'(lock), 1);

        // period shorter than MIN_PERIOD
        drive_period(15, 7);
        drive_period(100, 48);
        drive_period(100, 48);
        check_all("t5");
        chk("t5_lock_cleared", 32'(lock), 0);

        // enable drop flushes and clears lock, results hold
        repeat (4) drive_period(100, 60);
        check_all("en_pre");
        @(negedge clk);
        enable     = 1'b0;
        pend_valid = 1'b0;
        run_cnt    = 0;
        repeat (5) @(negedge clk);
        chk("en_lock_cleared", 32'(lock), 0);
        chk("en_period_hold", 32'(period), last_p);
        chk("en_bit_hold", 32'(bit_out), last_bit);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        repeat (3) drive_period(100, 30);
        check_all("en_post");

        // duty sequence 45,35,25,35 percent
        drive_period(100, 45);
        drive_period(100, 35);
        drive_period(100, 25);
        drive_period(100, 35);
        drive_period(100, 50);
        check_all("t6");

        // random periods, occasionally illegal-short
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(7, 0) == 0) p = $urandom_range(19, 12);
            else                           p = $urandom_range(300, 20);
            h = $urandom_range(p - 4, 4);
            drive_period(p, h);
        end
        check_all("rand");
        chk("rand_lock_final", 32'(lock), (run_cnt >= LOCK_CNT) ? 1 : 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
